// File: rtl/disp_pkg.sv
// Shared types and constants for the display scan controller.
//   MAX_DIGITS   : widest display the controller can scan
//   NIB_W        : bits per displayed digit value
//   IDX_W        : width of a digit position index
//   scan_state_e : scanner FSM states
//   seg_payload_t: what the segment encoder receives for one lit position
//   nib_at()     : extract the nibble of one position from the packed bus
package disp_pkg;

    localparam int unsigned MAX_DIGITS = 16;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned DATA_W     = MAX_DIGITS * NIB_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic [NIB_W-1:0] nib;
        logic             blank;
        logic             dp;
    } seg_payload_t;

    // Nibble i lives at data[4i+3:4i]; the index is scaled by a shift.
    function automatic logic [NIB_W-1:0] nib_at(
        input logic [DATA_W-1:0] data,
        input logic [IDX_W-1:0]  idx
    );
        return data[{idx, 2'b00} +: NIB_W];
    endfunction

endpackage

// File: rtl/lz_mask_gen.sv
// Leading-zero suppress mask generator (combinational).
//   nibbles    : shadowed packed digit values, position 0 least significant
//   lz_en      : shadowed leading-zero suppression enable
//   suppress_c : bit i set when position i must be blanked
// Position i>0 is suppressed when every nibble from DIGITS-1 down to i is 0.
// Position 0 is never suppressed, and positions >= DIGITS are never flagged.
module lz_mask_gen
    import disp_pkg::*;
#(
    parameter int unsigned DIGITS = 8
) (
    input  logic [DATA_W-1:0]     nibbles,
    input  logic                  lz_en,
    output logic [MAX_DIGITS-1:0] suppress_c
);

    localparam int unsigned BIT_IDX_W = $clog2(DATA_W);

    logic [MAX_DIGITS-1:0] is_zero;
    logic                  zero_run;

    // Per-position zero detect.
    always_comb begin
        is_zero = '0;
        for (int i = 0; i < int'(MAX_DIGITS); i++) begin
            is_zero[IDX_W'(i)] = (nibbles[BIT_IDX_W'(i * int'(NIB_W)) +: NIB_W] == '0);
        end
    end

    // Walk from the most significant scanned position down, keeping a
    // running "all zero so far" flag.
    always_comb begin
        suppress_c = '0;
        zero_run   = 1'b1;
        for (int i = int'(MAX_DIGITS) - 1; i >= 0; i--) begin
            if (i < int'(DIGITS)) begin
                zero_run = zero_run & is_zero[IDX_W'(i)];
                if (i != 0) begin
                    suppress_c[IDX_W'(i)] = lz_en & zero_run;
                end
            end
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed digit scanner for the counter display.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   run                : scanning enable; low returns to IDLE next cycle
//   digit_data         : 16 packed nibbles, position 0 least significant
//   dp_mask            : decimal-point request per position
//   lz_en              : leading-zero suppression enable
//   sel_idx, sel_en    : position index / enable for the 4-16 select decoder
//   seg_nib, seg_blank : nibble and all-off flag for the segment encoder
//   dp                 : decimal point for the lit position
//   frame_start        : one-cycle pulse on entry to SHOW at position 0
// Each position is lit SCAN_DIV cycles followed by BLANK_CYC dark cycles.
// Inputs are shadowed once per frame so a displayed frame never tears.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLANK_CYC = 500,
    parameter int unsigned DIGITS    = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  run,
    input  logic [DATA_W-1:0]     digit_data,
    input  logic [MAX_DIGITS-1:0] dp_mask,
    input  logic                  lz_en,
    output logic [IDX_W-1:0]      sel_idx,
    output logic                  sel_en,
    output logic [NIB_W-1:0]      seg_nib,
    output logic                  seg_blank,
    output logic                  dp,
    output logic                  frame_start
);

    localparam int unsigned SHOW_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLNK_W    = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int unsigned SHOW_LAST = (SCAN_DIV > 0) ? SCAN_DIV - 1 : 0;
    localparam int unsigned BLNK_LAST = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;
    localparam bit          HAS_BLANK = (BLANK_CYC != 0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    scan_state_e           state;
    logic [SHOW_W-1:0]     show_cnt;
    logic [BLNK_W-1:0]     blank_cnt;

    // Frame shadow of the inputs.
    logic [DATA_W-1:0]     data_q;
    logic [MAX_DIGITS-1:0] dpm_q;
    logic                  lz_q;

    logic                  show_done_c;
    logic                  blank_done_c;
    logic                  load_c;
    logic                  cap_c;
    logic [IDX_W-1:0]      nxt_idx_c;
    logic [DATA_W-1:0]     src_data_c;
    logic [MAX_DIGITS-1:0] src_dpm_c;
    logic [MAX_DIGITS-1:0] suppress_c;
    seg_payload_t          nxt_pl_c;

    // Suppress mask is derived from the shadow only. A capture edge always
    // loads position 0, which is never suppressed, so the mask is never
    // needed before the shadow holds the new frame.
    lz_mask_gen #(
        .DIGITS (DIGITS)
    ) u_lz_mask_gen (
        .nibbles    (data_q),
        .lz_en      (lz_q),
        .suppress_c (suppress_c)
    );

    assign show_done_c  = (show_cnt == SHOW_W'(SHOW_LAST));
    assign blank_done_c = (blank_cnt == BLNK_W'(BLNK_LAST));

    // Decide whether this edge enters SHOW, which position, and whether
    // it starts a new frame (and so re-captures the shadow).
    always_comb begin
        load_c    = 1'b0;
        cap_c     = 1'b0;
        nxt_idx_c = '0;
        if (run) begin
            unique case (state)
                IDLE: begin
                    load_c = 1'b1;
                    cap_c  = 1'b1;
                end
                SHOW: begin
                    if (show_done_c && !HAS_BLANK) begin
                        load_c = 1'b1;
                    end
                end
                BLANK: begin
                    if (blank_done_c) begin
                        load_c = 1'b1;
                    end
                end
                default: begin
                    load_c = 1'b0;
                end
            endcase
            if (load_c && (state != IDLE)) begin
                cap_c     = (sel_idx == IDX_LAST);
                nxt_idx_c = cap_c ? '0 : sel_idx + IDX_W'(1);
            end
        end
    end

    // On a capture edge the new frame comes straight from the inputs.
    assign src_data_c = cap_c ? digit_data : data_q;
    assign src_dpm_c  = cap_c ? dp_mask    : dpm_q;

    // Payload for the position about to be lit.
    always_comb begin
        nxt_pl_c.nib   = nib_at(src_data_c, nxt_idx_c);
        nxt_pl_c.dp    = src_dpm_c[nxt_idx_c];
        nxt_pl_c.blank = (nxt_idx_c == '0) ? 1'b0 : suppress_c[nxt_idx_c];
    end

    // Scanner FSM with registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            show_cnt    <= '0;
            blank_cnt   <= '0;
            data_q      <= '0;
            dpm_q       <= '0;
            lz_q        <= 1'b0;
            sel_idx     <= '0;
            sel_en      <= 1'b0;
            seg_nib     <= '0;
            seg_blank   <= 1'b1;
            dp          <= 1'b0;
            frame_start <= 1'b0;
        end else if (!run) begin
            state       <= IDLE;
            show_cnt    <= '0;
            blank_cnt   <= '0;
            sel_idx     <= '0;
            sel_en      <= 1'b0;
            seg_nib     <= '0;
            seg_blank   <= 1'b1;
            dp          <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (cap_c) begin
                data_q <= digit_data;
                dpm_q  <= dp_mask;
                lz_q   <= lz_en;
            end
            if (load_c) begin
                state       <= SHOW;
                show_cnt    <= '0;
                blank_cnt   <= '0;
                sel_idx     <= nxt_idx_c;
                sel_en      <= 1'b1;
                seg_nib     <= nxt_pl_c.nib;
                seg_blank   <= nxt_pl_c.blank;
                dp          <= nxt_pl_c.dp;
                frame_start <= (nxt_idx_c == '0);
            end else begin
                unique case (state)
                    SHOW: begin
                        if (show_done_c) begin
                            state     <= BLANK;
                            show_cnt  <= '0;
                            sel_en    <= 1'b0;
                            seg_blank <= 1'b1;
                            dp        <= 1'b0;
                        end else begin
                            show_cnt <= show_cnt + SHOW_W'(1);
                        end
                    end
                    BLANK: begin
                        blank_cnt <= blank_cnt + BLNK_W'(1);
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: a 4-digit instance with dead time
// and a 1-digit instance without, both compared every cycle against a
// frame-level reference model.
module tb_disp_scan_ctrl;

    localparam int SD0 = 4, BC0 = 2, ND0 = 4, F0 = (SD0 + BC0) * ND0;
    localparam int SD1 = 4, BC1 = 0, ND1 = 1, F1 = (SD1 + BC1) * ND1;
    // {sel_idx, sel_en, seg_nib, seg_blank, dp, frame_start}
    localparam logic [11:0] RST_V = 12'b0000_0_0000_1_0_0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run0 = 1'b0;
    logic        run1 = 1'b0;
    logic        lz_en = 1'b0;
    logic [63:0] digit_data = '0;
    logic [15:0] dp_mask = '0;

    logic [3:0] sel_idx0, seg_nib0, sel_idx1, seg_nib1;
    logic       sel_en0, seg_blank0, dp0, fs0;
    logic       sel_en1, seg_blank1, dp1, fs1;
    logic [11:0] obs0, obs1, exp0, exp1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.SCAN_DIV(SD0), .BLANK_CYC(BC0), .DIGITS(ND0)) u_dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .run(run0), .digit_data(digit_data),
        .dp_mask(dp_mask), .lz_en(lz_en), .sel_idx(sel_idx0), .sel_en(sel_en0),
        .seg_nib(seg_nib0), .seg_blank(seg_blank0), .dp(dp0), .frame_start(fs0));

    disp_scan_ctrl #(.SCAN_DIV(SD1), .BLANK_CYC(BC1), .DIGITS(ND1)) u_dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .run(run1), .digit_data(digit_data),
        .dp_mask(dp_mask), .lz_en(lz_en), .sel_idx(sel_idx1), .sel_en(sel_en1),
        .seg_nib(seg_nib1), .seg_blank(seg_blank1), .dp(dp1), .frame_start(fs1));

    assign obs0 = {sel_idx0, sel_en0, seg_nib0, seg_blank0, dp0, fs0};
    assign obs1 = {sel_idx1, sel_en1, seg_nib1, seg_blank1, dp1, fs1};

    // Reference model: cycle k within the current frame plus the data
    // captured when the frame began.
    logic        m0_act = 1'b0, m1_act = 1'b0;
    int          m0_k = 0, m1_k = 0;
    logic [63:0] m0_d = '0, m1_d = '0;
    logic [15:0] m0_m = '0, m1_m = '0;
    logic        m0_lz = 1'b0, m1_lz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !run0) begin
            m0_act <= 1'b0;
            m0_k   <= 0;
        end else if (!m0_act || m0_k == F0 - 1) begin
            m0_act <= 1'b1;
            m0_k   <= 0;
            m0_d   <= digit_data;
            m0_m   <= dp_mask;
            m0_lz  <= lz_en;
        end else begin
            m0_k <= m0_k + 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !run1) begin
            m1_act <= 1'b0;
            m1_k   <= 0;
        end else if (!m1_act || m1_k == F1 - 1) begin
            m1_act <= 1'b1;
            m1_k   <= 0;
            m1_d   <= digit_data;
            m1_m   <= dp_mask;
            m1_lz  <= lz_en;
        end else begin
            m1_k <= m1_k + 1;
        end
    end

    function automatic logic [11:0] model_out(input int sd, input int bc, input int nd,
                                              input logic act, input int k,
                                              input logic [63:0] d, input logic [15:0] m,
                                              input logic lz);
        int p, pos, ph;
        logic [3:0] nib;
        logic lit, blank, allz, dpb, fsb;
        if (!act) return RST_V;
        p    = sd + bc;
        pos  = k / p;
        ph   = k % p;
        lit  = (ph < sd);
        nib  = d[6'(pos * 4) +: 4];
        allz = 1'b1;
        for (int i = pos; i < nd; i++) begin
            if (d[6'(i * 4) +: 4] != 4'd0) allz = 1'b0;
        end
        blank = lit ? (lz && pos > 0 && allz) : 1'b1;
        dpb   = lit ? m[4'(pos)] : 1'b0;
        fsb   = (k == 0);
        return {4'(pos), lit, nib, blank, dpb, fsb};
    endfunction

    always_comb exp0 = model_out(SD0, BC0, ND0, m0_act, m0_k, m0_d, m0_m, m0_lz);
    always_comb exp1 = model_out(SD1, BC1, ND1, m1_act, m1_k, m1_d, m1_m, m1_lz);

    function automatic logic [63:0] rand_digits();
        logic [63:0] d;
        d = '0;
        for (int i = 0; i < 16; i++) begin
            d[6'(i * 4) +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
        end
        return d;
    endfunction

    // Bounded wait for a frame_start pulse on the 4-digit instance.
    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (fs0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++;
        if (obs0 !== RST_V) begin n_fail++; $display("FAIL reset_dut0 got=%h exp=%h", obs0, RST_V); end
        n_chk++;
        if (obs1 !== RST_V) begin n_fail++; $display("FAIL reset_dut1 got=%h exp=%h", obs1, RST_V); end
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (obs0 !== RST_V) begin n_fail++; $display("FAIL idle_after_reset got=%h exp=%h", obs0, RST_V); end
    endtask

    task automatic test_scan_basic();
        logic [7:0] seq_exp [4] = '{8'h01, 8'h12, 8'h23, 8'h34};
        int fs_cnt = 0;
        digit_data = 64'h4321; dp_mask = 16'h0; lz_en = 1'b0; run0 = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            n_chk++;
            if (obs0 !== exp0) begin n_fail++; $display("FAIL scan_model c=%0d got=%h exp=%h", c, obs0, exp0); end
            if (fs0) fs_cnt++;
            if (c < 24 && c % 6 == 0) begin
                n_chk++;
                if ({sel_idx0, seg_nib0} !== seq_exp[c / 6])
                    begin n_fail++; $display("FAIL scan_seq c=%0d got=%h exp=%h", c, {sel_idx0, seg_nib0}, seq_exp[c / 6]); end
            end
        end
        n_chk++;
        if (fs_cnt !== 3) begin n_fail++; $display("FAIL frame_count got=%0d exp=3", fs_cnt); end
    endtask

    task automatic test_lz();
        logic [5:0] lz_exp [4] = '{6'b10_0000, 6'b10_0101, 6'b11_0000, 6'b11_0000};
        bit ok;
        lz_en = 1'b1; digit_data = 64'h0050; dp_mask = 16'($urandom);
        wait_frame(ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL lz_frame_timeout got=0 exp=1"); end
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clk);
            n_chk++;
            if (obs0 !== exp0) begin n_fail++; $display("FAIL lz_model c=%0d got=%h exp=%h", c, obs0, exp0); end
            if (c % 6 == 0) begin
                n_chk++;
                if ({sel_en0, seg_blank0, seg_nib0} !== lz_exp[c / 6])
                    begin n_fail++; $display("FAIL lz_pos c=%0d got=%b exp=%b", c, {sel_en0, seg_blank0, seg_nib0}, lz_exp[c / 6]); end
            end
        end
    endtask

    task automatic test_no_tear();
        bit ok;
        lz_en = 1'b0; digit_data = 64'h1111;
        wait_frame(ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL tear_frame_timeout got=0 exp=1"); end
        for (int c = 0; c < 48; c++) begin
            if (c > 0) @(negedge clk);
            n_chk++;
            if (obs0 !== exp0) begin n_fail++; $display("FAIL tear_model c=%0d got=%h exp=%h", c, obs0, exp0); end
            if (c >= 6 && c % 6 == 0) begin
                n_chk++;
                if (seg_nib0 !== ((c < 24) ? 4'd1 : 4'd2))
                    begin n_fail++; $display("FAIL tear_nib c=%0d got=%0d exp=%0d", c, seg_nib0, (c < 24) ? 1 : 2); end
            end
            if (c == 8) digit_data = 64'h2222;
        end
    endtask

    task automatic test_run_drop();
        bit ok;
        wait_frame(ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL drop_frame_timeout got=0 exp=1"); end
        for (int c = 1; c <= 13; c++) @(negedge clk);
        run0 = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({sel_en0, sel_idx0} !== 5'b0_0000) begin n_fail++; $display("FAIL drop_idle got=%b exp=00000", {sel_en0, sel_idx0}); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++;
            if (obs0 !== exp0) begin n_fail++; $display("FAIL drop_model c=%0d got=%h exp=%h", c, obs0, exp0); end
        end
        run0 = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({fs0, sel_en0, sel_idx0, seg_nib0} !== {1'b1, 1'b1, 4'd0, 4'd2})
            begin n_fail++; $display("FAIL drop_restart got=%b exp=%b", {fs0, sel_en0, sel_idx0, seg_nib0}, {1'b1, 1'b1, 4'd0, 4'd2}); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_frame(ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL rstmid_frame_timeout got=0 exp=1"); end
        for (int c = 1; c <= 4; c++) @(negedge clk);
        n_chk++;
        if (sel_en0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_in_blank got=%b exp=0", sel_en0); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs0 !== RST_V) begin n_fail++; $display("FAIL rstmid_async got=%h exp=%h", obs0, RST_V); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        n_chk++;
        if (obs0 !== RST_V) begin n_fail++; $display("FAIL rstmid_release got=%h exp=%h", obs0, RST_V); end
        @(negedge clk);
        n_chk++;
        if ({fs0, sel_en0, sel_idx0} !== 6'b11_0000)
            begin n_fail++; $display("FAIL rstmid_restart got=%b exp=110000", {fs0, sel_en0, sel_idx0}); end
        n_chk++;
        if (obs0 !== exp0) begin n_fail++; $display("FAIL rstmid_model got=%h exp=%h", obs0, exp0); end
    endtask

    task automatic test_single_digit();
        int fs_cnt = 0;
        dp_mask = 16'h0001; run1 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_chk++;
            if (obs1 !== exp1) begin n_fail++; $display("FAIL single_model c=%0d got=%h exp=%h", c, obs1, exp1); end
            n_chk++;
            if ({sel_en1, sel_idx1, dp1} !== 6'b1_0000_1)
                begin n_fail++; $display("FAIL single_hold c=%0d got=%b exp=100001", c, {sel_en1, sel_idx1, dp1}); end
            if (fs1) fs_cnt++;
        end
        n_chk++;
        if (fs_cnt !== 5) begin n_fail++; $display("FAIL single_frames got=%0d exp=5", fs_cnt); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            n_chk++;
            if (obs0 !== exp0) begin n_fail++; $display("FAIL rand_dut0 c=%0d got=%h exp=%h", c, obs0, exp0); end
            n_chk++;
            if (obs1 !== exp1) begin n_fail++; $display("FAIL rand_dut1 c=%0d got=%h exp=%h", c, obs1, exp1); end
            if ($urandom_range(0, 7) == 0) digit_data = rand_digits();
            if ($urandom_range(0, 15) == 0) dp_mask = 16'($urandom);
            if ($urandom_range(0, 31) == 0) lz_en = 1'($urandom);
            if (run0) begin
                if ($urandom_range(0, 199) == 0) run0 = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                run0 = 1'b1;
            end
            if (run1) begin
                if ($urandom_range(0, 99) == 0) run1 = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                run1 = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_basic();
        test_lz();
        test_no_tear();
        test_run_drop();
        test_reset_mid();
        test_single_digit();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
